// File: rtl/rf_wb_arbiter_if.sv
// Write-back port bundle: two producer request channels, the register-file
// write port, and operand-address pending lookups.
interface rf_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd_address;
  logic [DATA_WIDTH-1:0] alu_rd_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_rd_address;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  rfwr_enable;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rs1_address;
  logic [ADDR_WIDTH-1:0] rs2_address;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic [CNT_WIDTH-1:0]  conflict_count;

  modport master (
    output alu_valid, alu_rd_address, alu_rd_data,
    output mem_valid, mem_rd_address, mem_rd_data,
    output rs1_address, rs2_address,
    input  alu_ready, mem_ready, rfwr_enable, rd_address, rd_data,
    input  rs1_pending, rs2_pending, conflict_count
  );

  modport slave (
    input  alu_valid, alu_rd_address, alu_rd_data,
    input  mem_valid, mem_rd_address, mem_rd_data,
    input  rs1_address, rs2_address,
    output alu_ready, mem_ready, rfwr_enable, rd_address, rd_data,
    output rs1_pending, rs2_pending, conflict_count
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Oldest-first arbiter of ALU/MEM writes onto one register-file port; one-cycle latency.
// Backpressure: a producer's ready drops only while its buffered write loses arbitration.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  rf_wb_arbiter_if.slave   wb
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  typedef struct packed {
    logic                  vld;
    logic                  seq;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat;
  } buf_t;

  buf_t                 alu_buf_q, alu_buf_d;
  buf_t                 mem_buf_q, mem_buf_d;
  logic                 seq_q, seq_d;
  grant_e               last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;

  logic grant_alu, grant_mem, alu_older, alu_acc, mem_acc;

  // Live entries are never more than one accepting edge apart, so one bit of
  // sequence suffices: the older entry is the one whose tag equals seq_q.
  always_comb begin
    alu_older = 1'b0;
    if (alu_buf_q.seq != mem_buf_q.seq) begin
      alu_older = (alu_buf_q.seq == seq_q);
    end else begin
      alu_older = (last_grant_q == GRANT_MEM);
    end
    grant_alu = alu_buf_q.vld && (!mem_buf_q.vld || alu_older);
    grant_mem = mem_buf_q.vld && !grant_alu;
  end

  assign wb.alu_ready = !alu_buf_q.vld || grant_alu;
  assign wb.mem_ready = !mem_buf_q.vld || grant_mem;

  // x0 requests complete the handshake but never occupy a buffer.
  assign alu_acc = wb.alu_valid && wb.alu_ready && (wb.alu_rd_address != '0);
  assign mem_acc = wb.mem_valid && wb.mem_ready && (wb.mem_rd_address != '0);

  always_comb begin
    alu_buf_d    = alu_buf_q;
    mem_buf_d    = mem_buf_q;
    seq_d        = seq_q ^ (alu_acc || mem_acc);
    last_grant_d = last_grant_q;
    conflict_d   = conflict_q;

    if (grant_alu) begin
      alu_buf_d.vld = 1'b0;
      last_grant_d  = GRANT_ALU;
    end
    if (grant_mem) begin
      mem_buf_d.vld = 1'b0;
      last_grant_d  = GRANT_MEM;
    end
    if (alu_acc) begin
      alu_buf_d.vld  = 1'b1;
      alu_buf_d.seq  = seq_q;
      alu_buf_d.addr = wb.alu_rd_address;
      alu_buf_d.dat  = wb.alu_rd_data;
    end
    if (mem_acc) begin
      mem_buf_d.vld  = 1'b1;
      mem_buf_d.seq  = seq_q;
      mem_buf_d.addr = wb.mem_rd_address;
      mem_buf_d.dat  = wb.mem_rd_data;
    end
    if (alu_buf_q.vld && mem_buf_q.vld && (conflict_q != '1)) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_buf_q    <= '0;
      mem_buf_q    <= '0;
      seq_q        <= 1'b0;
      last_grant_q <= GRANT_MEM;
      conflict_q   <= '0;
    end else begin
      alu_buf_q    <= alu_buf_d;
      mem_buf_q    <= mem_buf_d;
      seq_q        <= seq_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

  always_comb begin
    wb.rfwr_enable = grant_alu || grant_mem;
    wb.rd_address  = '0;
    wb.rd_data     = '0;
    if (grant_alu) begin
      wb.rd_address = alu_buf_q.addr;
      wb.rd_data    = alu_buf_q.dat;
    end else if (grant_mem) begin
      wb.rd_address = mem_buf_q.addr;
      wb.rd_data    = mem_buf_q.dat;
    end
  end

  assign wb.rs1_pending = (wb.rs1_address != '0) &&
                          ((alu_buf_q.vld && (alu_buf_q.addr == wb.rs1_address)) ||
                           (mem_buf_q.vld && (mem_buf_q.addr == wb.rs1_address)));
  assign wb.rs2_pending = (wb.rs2_address != '0) &&
                          ((alu_buf_q.vld && (alu_buf_q.addr == wb.rs2_address)) ||
                           (mem_buf_q.vld && (mem_buf_q.addr == wb.rs2_address)));

  assign wb.conflict_count = conflict_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Two producers, the ALU and the load/memory unit, share that port. Each producer gets a one-entry holding buffer with a valid/ready handshake. The arbiter orders conflicting writes oldest-first, drops writes to x0, and reports buffered-but-uncommitted writes to the operand-read stage. It sits between the execute/memory stages and the register file's `rfwr_enable`/`rd_address`/`rd_data` inputs.

## Interface
- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register address width (32 registers)
- `CNT_WIDTH`, 16, width of the conflict counter
- `clock` in 1: single clock, all state updates on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `alu_valid` in 1: ALU write request
- `alu_ready` out 1: ALU request accepted this edge when high with `alu_valid`
- `alu_rd_address` in ADDR_WIDTH: ALU destination register
- `alu_rd_data` in DATA_WIDTH: ALU write data
- `mem_valid` / `mem_ready` / `mem_rd_address` / `mem_rd_data`: same as ALU set, memory unit
- `rfwr_enable` out 1: register-file write enable
- `rd_address` out ADDR_WIDTH: register-file write address
- `rd_data` out DATA_WIDTH: register-file write data
- `rs1_address`, `rs2_address` in ADDR_WIDTH: operand addresses being read
- `rs1_pending`, `rs2_pending` out 1: a buffered write to that register is not yet committed
- `conflict_count` out CNT_WIDTH: saturating count of cycles with both buffers occupied

## Operation
- State:
  - per requester: `buf_valid`, `buf_addr`, `buf_data`, `buf_seq`
  - `seq` counter (1 bit suffices)
  - `last_grant` (ALU/MEM)
  - `conflict_count`
- Accept:
  - Occurs on `X_valid && X_ready` at a rising edge.
  - Address 0: the request is accepted and discarded. The buffer is unchanged and no write is ever issued.
  - Nonzero address: the buffer is loaded and marked valid.
- `X_ready = !buf_valid_X || grant_X`. A buffer being drained this cycle can refill on the same edge. Ready depends on registered state only, never on `X_valid`.
- Grant (combinational from registered state):
  - Only one buffer valid: grant it.
  - Both valid: grant the older entry, i.e. the one accepted on an earlier edge.
  - Both accepted on the same edge: grant the requester that is not `last_grant`.
- Write port:
  - `rfwr_enable = 1` when a grant exists; `rd_address`/`rd_data` come from the granted buffer.
  - No grant: all three outputs are 0.
  - The register file commits on the same edge that clears the granted buffer.
- `last_grant` updates on every grant.
- `rsN_pending = (rsN_address != 0) && any valid buffer with buf_addr == rsN_address`.
- `conflict_count` increments on each edge where both buffers are valid at the start of the cycle. It saturates at all-ones.
- Same-address writes from both requesters commit in acceptance order, so the register file ends with the younger value.

## Timing
- Reset (`reset_n` low, asynchronous):
  - Buffers empty; any buffered writes are discarded and never reach the register file.
  - `last_grant = MEM`, so the ALU wins the first tie.
  - `conflict_count = 0`.
  - `rfwr_enable = 0`, `rd_address = 0`, `rd_data = 0`.
  - `alu_ready = mem_ready = 1`; handshakes are ignored while `reset_n` is low.
- Latency: a request accepted at edge N appears on the write port during cycle N..N+1 and commits at edge N+1 if uncontested.
- Contested: the loser commits one edge later. Its `ready` is low for that one cycle.
- Throughput: one write per cycle total. A single active requester streams at full rate with `ready` held high.
- Outputs are combinational from registers only; no input-to-output paths except `rsN_address` to `rsN_pending`.

## Test plan
- ALU streaming:
  - Stimulus: `alu_valid` held high with x5=0xDEADBEEF, x6=0x1, x7=0x2 on consecutive edges.
  - Required: the write port shows each value one cycle after its acceptance; `alu_ready` stays 1; `conflict_count` stays 0.
- Tie:
  - Stimulus: ALU x3=0x11 and MEM x4=0x22 accepted on the same edge after reset.
  - Required: next cycle writes x3, then x4; `mem_ready=0` for one cycle; `conflict_count=1`.
- Ordering:
  - Stimulus: a tie of MEM x7=0xA and ALU x9=0x9, then ALU x7=0xB accepted on the edge the ALU drains.
  - Required: commit order x9, x7=0xA, x7=0xB; final x7=0xB.
- x0 write:
  - Stimulus: ALU x0=0xFFFFFFFF.
  - Required: accepted (`alu_ready=1`); `rfwr_enable` stays 0; `rs1_pending=0` with `rs1_address=0`.
- Pending:
  - Stimulus: MEM x4 buffered while ALU x2 holds the port; `rs1_address=4`, `rs2_address=8`.
  - Required: `rs1_pending=1` until the edge that commits x4; `rs2_pending=0`.
- Reset mid-operation:
  - Stimulus: both buffers full, `reset_n` pulsed low between edges.
  - Required: `rfwr_enable=0` immediately; no write to either register; `conflict_count=0`; both `ready=1`.
